// File: rtl/raycast_pkg.sv
// Shared ray-cast definitions: sentinel values, texture coordinate width and the
// resolver state encoding.
package raycast_pkg;

   localparam logic [15:0] DIST_NONE    = 16'hFFFF;
   localparam int          UV_W         = 8;
   localparam logic [7:0]  WALL_ID_NONE = 8'hFF;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCUM  = 2'd1,
      S_COMMIT = 2'd2
   } res_state_t;

endpackage

// File: rtl/column_buffer_ram.sv
// Simple dual-port column store: one synchronous write port, one registered read
// port. Contents are not reset; only the read register is cleared.
module column_buffer_ram #(
   parameter int DEPTH = 320,
   parameter int AW    = 9,
   parameter int DW    = 24
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   // Non-blocking read of mem gives old data on a same-cycle read/write collision.
   always_ff @(posedge clk) begin
      if (reset) rd_data <= '0;
      else       rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/column_hit_resolver.sv
// Nearest-hit resolver: keeps the closest candidate per column and commits it to
// the column buffer. Define HIT_WALL_ID_EN to also track and store a wall id.
module column_hit_resolver
   import raycast_pkg::*;
#(
   parameter int NUM_COLS = 320,
   parameter int COL_W    = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             col_start,
   input  logic [COL_W-1:0] col_idx,
   input  logic             hit_valid,
   input  logic [15:0]      hit_dist,
   input  logic [15:0]      hit_uv,
`ifdef HIT_WALL_ID_EN
   input  logic [7:0]       hit_wall_id,
   output logic [7:0]       rd_wall_id,
`endif
   input  logic             col_end,
   output logic             ready,
   output logic             col_done,
   output logic             frame_done,
   input  logic [COL_W-1:0] rd_addr,
   output logic [15:0]      rd_dist,
   output logic [UV_W-1:0]  rd_uv
);

`ifdef HIT_WALL_ID_EN
   localparam int BUF_W = 16 + UV_W + 8;
`else
   localparam int BUF_W = 16 + UV_W;
`endif

   res_state_t       state, state_n;
   logic [COL_W-1:0] col_q, col_n;
   logic [15:0]      best_dist, best_dist_n;
   logic [UV_W-1:0]  best_uv, best_uv_n;
   logic [7:0]       best_id, best_id_n;
   logic             fold, start_ok, we;
   logic [BUF_W-1:0] wr_word, rd_word;

`ifdef HIT_WALL_ID_EN
   logic [7:0] cand_id;
   assign cand_id = hit_wall_id;
`else
   logic [7:0] cand_id;
   assign cand_id = WALL_ID_NONE;
`endif

   // Strict compare: ties keep the earlier hit and DIST_NONE can never win.
   assign fold     = hit_valid && (hit_dist < best_dist);
   assign start_ok = col_start && (int'(col_idx) < NUM_COLS);

   always_comb begin
      state_n     = state;
      col_n       = col_q;
      best_dist_n = best_dist;
      best_uv_n   = best_uv;
      best_id_n   = best_id;
      we          = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_ok) begin
               col_n       = col_idx;
               best_dist_n = DIST_NONE;
               best_uv_n   = '0;
               best_id_n   = WALL_ID_NONE;
               state_n     = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (col_end) begin
               if (fold) begin
                  best_dist_n = hit_dist;
                  best_uv_n   = hit_uv[UV_W-1:0];
                  best_id_n   = cand_id;
               end
               state_n = S_COMMIT;
            end else if (start_ok) begin
               col_n       = col_idx;
               best_dist_n = DIST_NONE;
               best_uv_n   = '0;
               best_id_n   = WALL_ID_NONE;
            end else if (fold) begin
               best_dist_n = hit_dist;
               best_uv_n   = hit_uv[UV_W-1:0];
               best_id_n   = cand_id;
            end
         end
         S_COMMIT: begin
            we      = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         col_q      <= '0;
         best_dist  <= '0;
         best_uv    <= '0;
         best_id    <= '0;
         col_done   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         col_q      <= col_n;
         best_dist  <= best_dist_n;
         best_uv    <= best_uv_n;
         best_id    <= best_id_n;
         col_done   <= (state == S_COMMIT);
         frame_done <= (state == S_COMMIT) && (int'(col_q) == NUM_COLS - 1);
      end
   end

   assign ready = (state != S_COMMIT);

`ifdef HIT_WALL_ID_EN
   assign wr_word    = {best_id, best_dist, best_uv};
   assign rd_wall_id = rd_word[BUF_W-1 -: 8];
`else
   assign wr_word = {best_dist, best_uv};
`endif
   assign rd_dist = rd_word[UV_W +: 16];
   assign rd_uv   = rd_word[UV_W-1:0];

   // A reset landing on the COMMIT cycle discards the column.
   column_buffer_ram #(
      .DEPTH(NUM_COLS),
      .AW   (COL_W),
      .DW   (BUF_W)
   ) u_buf (
      .clk    (clk),
      .reset  (reset),
      .we     (we && !reset),
      .wr_addr(col_q),
      .wr_data(wr_word),
      .rd_addr(rd_addr),
      .rd_data(rd_word)
   );

endmodule

// File: doc/column_hit_resolver.md
# column_hit_resolver

Nearest-hit resolver and column depth buffer, directly downstream of the ray-cast register/intersection stage. For each screen column it receives a stream of per-wall candidates (distance, texture u), keeps the closest one, and commits it to an on-chip column buffer. The display/texture side reads the buffer through a registered read port.

## Interface
- NUM_COLS, 320: screen columns; buffer depth.
- COL_W, 9: column index width; must satisfy 2^COL_W >= NUM_COLS.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- col_start  in  1  begin a new column; col_idx sampled this cycle
- col_idx  in  COL_W  column being resolved
- hit_valid  in  1  candidate present this cycle
- hit_dist  in  16  candidate distance, unsigned Q8.8; 16'hFFFF = no intersection
- hit_uv  in  16  candidate texture u; only bits [7:0] used
- col_end  in  1  all candidates for current column delivered
- ready  out  1  high when not in COMMIT
- col_done  out  1  one-cycle pulse after a column is written
- frame_done  out  1  one-cycle pulse, coincident with col_done for column NUM_COLS-1
- rd_addr  in  COL_W  read column address
- rd_dist  out  16  stored nearest distance
- rd_uv  out  8  stored texture u

## Operation
- States: IDLE, ACCUM, COMMIT.
- IDLE: col_start with col_idx < NUM_COLS -> latch col_idx, best_dist = 16'hFFFF, best_uv = 0, go ACCUM. col_start with col_idx >= NUM_COLS ignored. hit_valid and col_end ignored.
- ACCUM: hit_valid && hit_dist < best_dist (unsigned, strict) -> best_dist = hit_dist, best_uv = hit_uv[7:0]. Ties keep earlier candidate. 16'hFFFF never replaces.
- ACCUM + col_end -> COMMIT. A hit_valid in the same cycle is folded in first.
- ACCUM + col_start (no col_end) -> abandon the column without writing, reinitialise with the new col_idx, and stay in ACCUM. col_start and col_end in the same cycle: col_end wins and col_start is ignored.
- COMMIT: write {best_dist, best_uv} to buffer[col], then go IDLE. All inputs except rd_addr are ignored. ready = 0.
- A column with no hits commits 16'hFFFF / 0.
- Read port is independent of the FSM. Reading an address in the same cycle it is written returns the old data.
- Reset: state IDLE, ready 1, col_done 0, frame_done 0, rd_dist 0, rd_uv 0, best registers cleared. Buffer contents are not reset.
- Reset mid-column or in COMMIT: the column is discarded and no write occurs.

## Timing
- col_start in cycle 0 -> ACCUM in cycle 1. The first candidate counted is in cycle 1.
- col_end in cycle n -> COMMIT in cycle n+1. Buffer is written at the edge ending cycle n+1.
- col_done and frame_done are high in cycle n+2. ready returns in cycle n+2.
- Minimum column period: 3 cycles (start, end, commit). Back-to-back col_start is accepted in cycle n+2.
- Read latency: 1 cycle (rd_addr in cycle k -> data in cycle k+1).

## Configuration
- HIT_WALL_ID_EN defined:
  - Adds input hit_wall_id[7:0] and output rd_wall_id[7:0].
  - The ID is tracked with best_dist under the same replace rule and stored per column. A no-hit column stores 8'hFF.
  - rd_wall_id reset value is 0.
- HIT_WALL_ID_EN undefined: these ports and the storage are absent; buffer word is 24 bits.

## Structure
- Shared package raycast_pkg holds:
  - DIST_NONE = 16'hFFFF
  - UV_W = 8
  - WALL_ID_NONE = 8'hFF
  - resolver state enum
- Sub-module column_buffer_ram: simple dual-port memory, one synchronous write and one registered read, parameterised on depth and width.

## Test plan
- Column 5: hits 0x0300, 0x0180/uv 0x22, 0x0200 -> rd_addr 5 gives rd_dist 0x0180, rd_uv 0x22; col_done in cycle n+2.
- Column 7: no hits, only 0xFFFF candidates -> stored 0xFFFF / 0x00.
- Tie 0x0100 uv 0x11, then 0x0100 uv 0x44 -> uv 0x11. A hit with col_end in the same cycle, distance 0x0050 -> committed 0x0050.
- Restart: col_start 10, hit 0x0080, col_start 11, hit 0x0400, col_end -> column 11 = 0x0400; column 10 unchanged.
- Sweep columns 0..319 with distance = index -> frame_done exactly once, with column 319. col_idx 320 ignored; ready low only in COMMIT.
- Reset asserted in ACCUM and then in COMMIT -> no buffer write; all outputs return to reset values next cycle.
